// File: rtl/u_lsu_store_buffer_if.sv
// LSU / Dmem bus bundle for the store buffer.
// The slave view belongs to the buffer; the master view belongs to the LSU and Dmem side.
interface u_lsu_store_buffer_if #(
    parameter int DATA_MEM_WIDTH     = 128,
    parameter int DATA_MEM_DEPTH_BIT = 9
);
    logic [DATA_MEM_WIDTH-1:0]     lsu_sb_wen;
    logic [DATA_MEM_WIDTH-1:0]     lsu_sb_wr_data;
    logic [DATA_MEM_DEPTH_BIT-1:0] lsu_sb_addr;
    logic                          lsu_sb_ren;
    logic                          sb_lsu_full;
    logic [DATA_MEM_WIDTH-1:0]     sb_lsu_rd_data;
    logic [DATA_MEM_DEPTH_BIT-1:0] sb_dmem_addr;
    logic                          sb_dmem_ren;
    logic [DATA_MEM_WIDTH-1:0]     sb_dmem_wen;
    logic [DATA_MEM_WIDTH-1:0]     sb_dmem_wr_data;
    logic [DATA_MEM_WIDTH-1:0]     dmem_sb_rd_data;
    logic                          sb_empty;
    logic                          sb_ovf_err;

    modport slave (
        input  lsu_sb_wen, lsu_sb_wr_data, lsu_sb_addr, lsu_sb_ren, dmem_sb_rd_data,
        output sb_lsu_full, sb_lsu_rd_data, sb_dmem_addr, sb_dmem_ren,
               sb_dmem_wen, sb_dmem_wr_data, sb_empty, sb_ovf_err
    );

    modport master (
        output lsu_sb_wen, lsu_sb_wr_data, lsu_sb_addr, lsu_sb_ren, dmem_sb_rd_data,
        input  sb_lsu_full, sb_lsu_rd_data, sb_dmem_addr, sb_dmem_ren,
               sb_dmem_wen, sb_dmem_wr_data, sb_empty, sb_ovf_err
    );
endinterface

// File: rtl/u_lsu_store_buffer.sv
// Line-wide store buffer between LSU and single-port Dmem: FIFO of masked stores,
// drained only in load-free cycles, with load data merged against buffered stores.
module u_lsu_store_buffer #(
    parameter int SB_DEPTH           = 4,
    parameter int DATA_MEM_WIDTH     = 128,
    parameter int DATA_MEM_DEPTH_BIT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    u_lsu_store_buffer_if.slave     bus_io
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic                          valid_q [SB_DEPTH];
    logic [DATA_MEM_DEPTH_BIT-1:0] addr_q  [SB_DEPTH];
    logic [DATA_MEM_WIDTH-1:0]     mask_q  [SB_DEPTH];
    logic [DATA_MEM_WIDTH-1:0]     data_q  [SB_DEPTH];
    logic [PW-1:0]                 head_q, tail_q;
    logic [CW-1:0]                 count_q;
    logic                          ovfErr_q;
    logic [DATA_MEM_WIDTH-1:0]     fwdData_q, fwdMask_q;
    logic [DATA_MEM_WIDTH-1:0]     fwdData_d, fwdMask_d;

    logic          storeReq, isFull, drain, combine, alloc;
    logic [PW-1:0] youngIdx;

    assign storeReq = |bus_io.lsu_sb_wen;
    assign isFull   = (count_q == CW'(SB_DEPTH));
    assign drain    = (count_q != '0) && !bus_io.lsu_sb_ren;
    assign youngIdx = tail_q - PW'(1);

    // Combining into the head entry while it drains would lose the new bits, so allocate instead.
    assign combine  = storeReq && !isFull && (count_q != '0) &&
                      (addr_q[youngIdx] == bus_io.lsu_sb_addr) &&
                      !(drain && (youngIdx == head_q));
    assign alloc    = storeReq && !isFull && !combine;

    // Walk oldest to youngest so the youngest store owns each overlapping bit.
    always_comb begin
        fwdData_d = '0;
        fwdMask_d = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid_q[head_q + PW'(i)] && (addr_q[head_q + PW'(i)] == bus_io.lsu_sb_addr)) begin
                fwdData_d = (fwdData_d & ~mask_q[head_q + PW'(i)]) |
                            (data_q[head_q + PW'(i)] & mask_q[head_q + PW'(i)]);
                fwdMask_d = fwdMask_d | mask_q[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                mask_q[i]  <= '0;
                data_q[i]  <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovfErr_q  <= 1'b0;
            fwdData_q <= '0;
            fwdMask_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= bus_io.lsu_sb_addr;
                mask_q[tail_q]  <= bus_io.lsu_sb_wen;
                data_q[tail_q]  <= bus_io.lsu_sb_wr_data;
                tail_q          <= tail_q + PW'(1);
            end
            if (combine) begin
                data_q[youngIdx] <= (data_q[youngIdx] & ~bus_io.lsu_sb_wen) |
                                    (bus_io.lsu_sb_wr_data & bus_io.lsu_sb_wen);
                mask_q[youngIdx] <= mask_q[youngIdx] | bus_io.lsu_sb_wen;
            end
            count_q <= count_q + CW'(alloc) - CW'(drain);
            if (storeReq && isFull) begin
                ovfErr_q <= 1'b1;
            end
            if (bus_io.lsu_sb_ren) begin
                fwdData_q <= fwdData_d;
                fwdMask_q <= fwdMask_d;
            end else begin
                fwdMask_q <= '0;
            end
        end
    end

    assign bus_io.sb_dmem_ren     = bus_io.lsu_sb_ren;
    assign bus_io.sb_dmem_addr    = bus_io.lsu_sb_ren ? bus_io.lsu_sb_addr : addr_q[head_q];
    assign bus_io.sb_dmem_wen     = drain ? mask_q[head_q] : '0;
    assign bus_io.sb_dmem_wr_data = data_q[head_q];
    assign bus_io.sb_lsu_rd_data  = (bus_io.dmem_sb_rd_data & ~fwdMask_q) | (fwdData_q & fwdMask_q);
    assign bus_io.sb_lsu_full     = isFull;
    assign bus_io.sb_empty        = (count_q == '0);
    assign bus_io.sb_ovf_err      = ovfErr_q;

endmodule

// File: tb/tb_u_lsu_store_buffer.sv
// Directed self-checking bench for u_lsu_store_buffer with a behavioural single-port Dmem.
module tb_u_lsu_store_buffer;
    localparam int W = 128;
    localparam int A = 9;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bit [W-1:0] mem [512];
    bit [W-1:0] dmemRdData;
    int         logAddr[$];

    u_lsu_store_buffer_if #(.DATA_MEM_WIDTH(W), .DATA_MEM_DEPTH_BIT(A)) bus ();

    u_lsu_store_buffer #(.SB_DEPTH(4), .DATA_MEM_WIDTH(W), .DATA_MEM_DEPTH_BIT(A)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Dmem model: masked write commits at the edge, read data registered one cycle after ren.
    assign bus.dmem_sb_rd_data = dmemRdData;
    always @(posedge clk) begin
        if (|bus.sb_dmem_wen) begin
            mem[bus.sb_dmem_addr] <= (mem[bus.sb_dmem_addr] & ~bus.sb_dmem_wen) |
                                     (bus.sb_dmem_wr_data & bus.sb_dmem_wen);
            logAddr.push_back(int'(bus.sb_dmem_addr));
        end
        if (bus.sb_dmem_ren) dmemRdData <= mem[bus.sb_dmem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] wen, input logic [W-1:0] data,
                         input int addr, input logic ren);
        bus.lsu_sb_wen     = wen;
        bus.lsu_sb_wr_data = data;
        bus.lsu_sb_addr    = A'(addr);
        bus.lsu_sb_ren     = ren;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('0, '0, 0, 1'b0);
        tick();
        tick();
        checks++; if (bus.sb_lsu_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.sb_lsu_full); end
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.sb_empty); end
        checks++; if (bus.sb_ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", bus.sb_ovf_err); end
        bus.lsu_sb_ren = 1'b1;
        #1;
        checks++; if (bus.sb_dmem_ren !== 1'b1) begin errors++; $display("[TB] FAIL reset_dmem_ren: got %0b expected 1", bus.sb_dmem_ren); end
        checks++; if (bus.sb_dmem_wen !== '0) begin errors++; $display("[TB] FAIL reset_dmem_wen: got %h expected 0", bus.sb_dmem_wen); end
        bus.lsu_sb_ren = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        int base;
        base = logAddr.size();
        for (int k = 1; k <= 4; k++) begin
            drive('1, {16{8'(k)}}, k, 1'b1);
            tick();
            if (k == 3) begin
                checks++; if (bus.sb_lsu_full !== 1'b0) begin errors++; $display("[TB] FAIL fill_not_full_at_3: got %0b expected 0", bus.sb_lsu_full); end
            end
        end
        checks++; if (bus.sb_lsu_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %0b expected 1", bus.sb_lsu_full); end
        for (int k = 1; k <= 4; k++) begin
            drive('0, '0, 0, 1'b0);
            #1;
            if (k == 1) begin
                checks++; if (bus.sb_lsu_full !== 1'b1) begin errors++; $display("[TB] FAIL full_during_drain: got %0b expected 1", bus.sb_lsu_full); end
            end
            checks++; if (bus.sb_dmem_wen !== '1) begin errors++; $display("[TB] FAIL drain_wen_%0d: got %h expected all ones", k, bus.sb_dmem_wen); end
            checks++; if (bus.sb_dmem_addr !== A'(k)) begin errors++; $display("[TB] FAIL drain_addr_%0d: got %0d expected %0d", k, bus.sb_dmem_addr, k); end
            checks++; if (bus.sb_dmem_wr_data !== {16{8'(k)}}) begin errors++; $display("[TB] FAIL drain_data_%0d: got %h expected %h", k, bus.sb_dmem_wr_data, {16{8'(k)}}); end
            tick();
        end
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %0b expected 1", bus.sb_empty); end
        checks++; if (logAddr.size() - base !== 4) begin errors++; $display("[TB] FAIL drain_write_count: got %0d expected 4", logAddr.size() - base); end
    endtask

    task automatic test_write_combine();
        drive(128'hFF, 128'h11, 5, 1'b0);
        tick();
        drive(128'hFF00, 128'h2200, 5, 1'b1);
        tick();
        checks++; if (bus.sb_lsu_rd_data !== 128'h11) begin errors++; $display("[TB] FAIL combine_load_excludes_same_cycle: got %h expected %h", bus.sb_lsu_rd_data, 128'h11); end
        drive('0, '0, 0, 1'b0);
        #1;
        checks++; if (bus.sb_dmem_wen !== 128'hFFFF) begin errors++; $display("[TB] FAIL combine_mask: got %h expected %h", bus.sb_dmem_wen, 128'hFFFF); end
        checks++; if (bus.sb_dmem_wr_data !== 128'h2211) begin errors++; $display("[TB] FAIL combine_data: got %h expected %h", bus.sb_dmem_wr_data, 128'h2211); end
        checks++; if (bus.sb_dmem_addr !== A'(5)) begin errors++; $display("[TB] FAIL combine_addr: got %0d expected 5", bus.sb_dmem_addr); end
        tick();
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL combine_single_entry: got %0b expected 1", bus.sb_empty); end
    endtask

    task automatic test_forwarding();
        drive('1, {16{8'hAA}}, 7, 1'b0);
        tick();
        drive('0, '0, 0, 1'b0);
        tick();
        drive(128'hFFFF_FFFF, 128'h1234_5678, 7, 1'b0);
        tick();
        drive('0, '0, 7, 1'b1);
        #1;
        checks++; if (bus.sb_dmem_wen !== '0) begin errors++; $display("[TB] FAIL fwd_wen_during_load: got %h expected 0", bus.sb_dmem_wen); end
        checks++; if (bus.sb_dmem_addr !== A'(7)) begin errors++; $display("[TB] FAIL fwd_load_addr: got %0d expected 7", bus.sb_dmem_addr); end
        tick();
        checks++; if (bus.sb_lsu_rd_data !== {{12{8'hAA}}, 32'h1234_5678}) begin errors++; $display("[TB] FAIL fwd_merge: got %h expected %h", bus.sb_lsu_rd_data, {{12{8'hAA}}, 32'h1234_5678}); end
        drive('0, '0, 0, 1'b0);
        tick();
        checks++; if (bus.sb_lsu_rd_data !== {16{8'hAA}}) begin errors++; $display("[TB] FAIL fwd_mask_clears: got %h expected %h", bus.sb_lsu_rd_data, {16{8'hAA}}); end
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL fwd_drained: got %0b expected 1", bus.sb_empty); end
    endtask

    task automatic test_age_ordering();
        int base;
        base = logAddr.size();
        drive(128'hFF, 128'h11, 3, 1'b1);
        tick();
        drive('1, {16{8'h44}}, 4, 1'b1);
        tick();
        drive(128'hFF, 128'h22, 3, 1'b1);
        tick();
        drive('0, '0, 3, 1'b1);
        tick();
        checks++; if (bus.sb_lsu_rd_data !== {{15{8'h03}}, 8'h22}) begin errors++; $display("[TB] FAIL age_youngest_wins: got %h expected %h", bus.sb_lsu_rd_data, {{15{8'h03}}, 8'h22}); end
        drive('0, '0, 0, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL age_empty: got %0b expected 1", bus.sb_empty); end
        checks++; if (logAddr.size() - base !== 3) begin errors++; $display("[TB] FAIL age_write_count: got %0d expected 3", logAddr.size() - base); end
        else begin
            checks++; if (logAddr[base+1] !== 4) begin errors++; $display("[TB] FAIL age_drain_order: got %0d expected 4", logAddr[base+1]); end
        end
    endtask

    task automatic test_enqueue_drain();
        drive(128'hF0, 128'hA0, 30, 1'b0);
        tick();
        drive(128'h0F, 128'h05, 30, 1'b0);
        #1;
        checks++; if (bus.sb_dmem_wen !== 128'hF0) begin errors++; $display("[TB] FAIL encdrain_head_wen: got %h expected %h", bus.sb_dmem_wen, 128'hF0); end
        tick();
        checks++; if (bus.sb_empty !== 1'b0) begin errors++; $display("[TB] FAIL encdrain_new_entry: got %0b expected 0", bus.sb_empty); end
        drive('0, '0, 0, 1'b0);
        #1;
        checks++; if (bus.sb_dmem_wen !== 128'h0F) begin errors++; $display("[TB] FAIL encdrain_second_wen: got %h expected %h", bus.sb_dmem_wen, 128'h0F); end
        checks++; if (bus.sb_dmem_wr_data !== 128'h05) begin errors++; $display("[TB] FAIL encdrain_second_data: got %h expected %h", bus.sb_dmem_wr_data, 128'h05); end
        tick();
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL encdrain_empty: got %0b expected 1", bus.sb_empty); end
    endtask

    task automatic test_overflow();
        int base;
        int found9;
        base = logAddr.size();
        for (int k = 10; k <= 13; k++) begin
            drive('1, {16{8'(k)}}, k, 1'b1);
            tick();
        end
        for (int n = 0; n < 3; n++) begin
            drive('1, '1, 9, 1'b1);
            tick();
            checks++; if (bus.sb_ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_%0d: got %0b expected 1", n, bus.sb_ovf_err); end
            checks++; if (bus.sb_lsu_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_count_held_%0d: got %0b expected 1", n, bus.sb_lsu_full); end
        end
        drive('0, '0, 0, 1'b0);
        for (int n = 0; n < 4; n++) tick();
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drained: got %0b expected 1", bus.sb_empty); end
        checks++; if (bus.sb_ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", bus.sb_ovf_err); end
        found9 = 0;
        foreach (logAddr[i]) if (logAddr[i] == 9) found9++;
        checks++; if (found9 !== 0) begin errors++; $display("[TB] FAIL ovf_line9_written: got %0d writes expected 0", found9); end
        checks++; if (logAddr.size() - base !== 4) begin errors++; $display("[TB] FAIL ovf_write_count: got %0d expected 4", logAddr.size() - base); end
        else begin
            checks++; if (logAddr[base+3] !== 13) begin errors++; $display("[TB] FAIL ovf_last_line: got %0d expected 13", logAddr[base+3]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        for (int k = 20; k <= 22; k++) begin
            drive('1, {16{8'(k)}}, k, 1'b1);
            tick();
        end
        base = logAddr.size();
        drive('0, '0, 0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty: got %0b expected 1", bus.sb_empty); end
        checks++; if (bus.sb_dmem_wen !== '0) begin errors++; $display("[TB] FAIL rstmid_wen: got %h expected 0", bus.sb_dmem_wen); end
        checks++; if (bus.sb_ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ovf_clear: got %0b expected 0", bus.sb_ovf_err); end
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        checks++; if (logAddr.size() !== base) begin errors++; $display("[TB] FAIL rstmid_no_writes: got %0d expected %0d", logAddr.size(), base); end
        checks++; if (bus.sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty_after: got %0b expected 1", bus.sb_empty); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_drain();
        test_write_combine();
        test_forwarding();
        test_age_ordering();
        test_enqueue_drain();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
